// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and helpers for the PageRank AXI read arbiter.
package axi_rd_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_64B = 3'd6;
  localparam int         RD_ARB_CNT_W = 4;

  // Width of a requester index; never zero so single-requester builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping mod N_REQ.
module rr_pick
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && elig[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI read channel between N_REQ requesters; ARID carries the
// requester index and returning beats are steered back by RID.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [64*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]    req_len,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [511:0]          resp_data,
  output logic                  resp_last,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic                  err,
  output logic [15:0]           arid_m,
  output logic [63:0]           araddr_m,
  output logic [7:0]            arlen_m,
  output logic [2:0]            arsize_m,
  output logic                  arvalid_m,
  input  logic                  arready_m,
  input  logic [15:0]           rid_m,
  input  logic [511:0]          rdata_m,
  input  logic [1:0]            rresp_m,
  input  logic                  rlast_m,
  input  logic                  rvalid_m,
  output logic                  rready_m
);

  localparam int IDX_W = idx_w(N_REQ);

  logic [RD_ARB_CNT_W-1:0] out_cnt [N_REQ];
  logic [IDX_W-1:0]        ptr;
  logic [N_REQ-1:0]        elig, grant, inc, dec;
  logic [IDX_W-1:0]        pick_idx;
  logic                    any, slot_free, rid_ok, r_hs;
  logic [63:0]             sel_addr;
  logic [7:0]              sel_len;

  // Grant stage: eligibility, pick, and the fields the AR slot will load.
  always_comb begin
    elig     = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (out_cnt[i] < RD_ARB_CNT_W'(MAX_OUT));
      if (grant[i]) begin
        sel_addr = req_addr[64*i +: 64];
        sel_len  = req_len[8*i +: 8];
      end
    end
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .elig      (elig),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (pick_idx),
    .any       (any)
  );

  assign slot_free = !arvalid_m || arready_m;
  assign req_ready = slot_free ? grant : '0;
  assign arsize_m  = AXI_SIZE_64B;

  // AR slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_m <= 1'b0;
      arid_m    <= '0;
      araddr_m  <= '0;
      arlen_m   <= '0;
      ptr       <= IDX_W'(N_REQ - 1);
    end else if (slot_free) begin
      arvalid_m <= any;
      if (any) begin
        arid_m   <= 16'(pick_idx);
        araddr_m <= sel_addr;
        arlen_m  <= sel_len;
        ptr      <= pick_idx;
      end
    end
  end

  // R routing: steer the beat by RID, drop unknown IDs with rready held high.
  assign resp_data = rdata_m;
  assign resp_last = rlast_m;

  always_comb begin
    resp_valid = '0;
    rid_ok     = 1'b0;
    rready_m   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rid_m == 16'(i)) begin
        rid_ok        = 1'b1;
        resp_valid[i] = rvalid_m;
        rready_m      = rvalid_m && resp_ready[i];
      end
    end
    if (!rid_ok) rready_m = rvalid_m;
  end

  assign r_hs = rvalid_m && rready_m;

  // Outstanding counters; a last beat on an idle counter belongs to a pre-reset burst.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      inc[i] = slot_free && grant[i];
      dec[i] = r_hs && rlast_m && (rid_m == 16'(i)) && (out_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst)                    out_cnt[i] <= '0;
      else if (inc[i] && !dec[i]) out_cnt[i] <= out_cnt[i] + 1'b1;
      else if (dec[i] && !inc[i]) out_cnt[i] <= out_cnt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                   err <= 1'b0;
    else if (r_hs && (rresp_m != 2'b00 || !rid_ok)) err <= 1'b1;
  end

endmodule
